// File: rtl/mcpu_pkg.sv
// mcpu_pkg
// Shared definitions for the MCPU boot path: the program loader state
// encoding, the instruction word width, and the opcode constants. Benches
// use the opcode constants and mk_instr() to build program images.
// No ports (package).
package mcpu_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    CLEAR,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

  // An instruction word is {opcode, operand}, with an 8-bit field for each.
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_AND   = 8'h03;
  localparam logic [7:0] OP_LOAD  = 8'h80;
  localparam logic [7:0] OP_STORE = 8'h81;
  localparam logic [7:0] OP_JMP   = 8'h90;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [7:0] op,
                                                  input logic [7:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/mcpu_prog_loader_if.sv
// mcpu_prog_loader_if
// Bundles the loader's byte-stream input, RAM write port and CPU control
// outputs.
//   in_data/in_valid/in_ready : byte stream; a byte transfers when valid && ready
//   mem_we/mem_addr/mem_wdata : RAM write port, one 16-bit word per cycle
//   cpu_reset                 : active-high reset held on the MCPU
//   load_done/load_err        : sticky completion and failure flags
// Modports:
//   master : stream source / system side (drives the stream, observes the rest)
//   slave  : the loader itself
interface mcpu_prog_loader_if #(
  parameter int ADDR_W = 8
);
  import mcpu_pkg::*;

  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               cpu_reset;
  logic               load_done;
  logic               load_err;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, load_done, load_err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, load_done, load_err
  );

endinterface

// File: rtl/mcpu_prog_loader.sv
// mcpu_prog_loader
// Boot-time program loader for the MCPU RAM. After reset it zero-fills the
// whole RAM, then takes a stream of the form
//   LEN_HI, LEN_LO, N x (word high byte, word low byte), CSUM
// and writes word k to address k. CSUM is the XOR of all bytes before it.
// The CPU is held in reset until the image is loaded and the checksum
// matches.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous, active-low reset
//   bus     : mcpu_prog_loader_if.slave (stream in, RAM write port out,
//             cpu_reset / load_done / load_err out)
module mcpu_prog_loader
  import mcpu_pkg::*;
#(
  parameter int RAM_SIZE = 256,
  parameter int ADDR_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  mcpu_prog_loader_if.slave  bus
);

  localparam logic [16:0] RAM_SIZE_W = 17'(RAM_SIZE);

  loader_state_t      state_q;
  logic [15:0]        wordCnt_q;
  logic [15:0]        len_q;
  logic [7:0]         xorAcc_q;
  logic [7:0]         hiByte_q;
  logic               memWe_q;
  logic [ADDR_W-1:0]  memAddr_q;
  logic [INSTR_W-1:0] memWdata_q;

  logic               inReady;
  logic               accept;
  logic [15:0]        len_d;

  // The stream is open only in the receiving states; in CLEAR, DONE and
  // ERROR any offered byte is left on the bus and never consumed.
  assign inReady = (state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM});
  assign accept  = bus.in_valid && inReady;

  // The full length as it stands once the low length byte arrives.
  assign len_d = {len_q[15:8], bus.in_data};

  // Single FSM register block. In CLEAR the counter also walks addresses
  // 0..RAM_SIZE-1. It is then allowed to reach RAM_SIZE, costing one more
  // cycle with no write, so that in_ready comes up only after the last
  // zero write has been issued. The counter, length and XOR are compared
  // at full width, so an N above RAM_SIZE is caught and never aliases
  // onto a small address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      wordCnt_q  <= '0;
      len_q      <= '0;
      xorAcc_q   <= '0;
      hiByte_q   <= '0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      memWe_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          if ({1'b0, wordCnt_q} == RAM_SIZE_W) begin
            state_q   <= LEN_HI;
            wordCnt_q <= '0;
            xorAcc_q  <= '0;
          end else begin
            memWe_q    <= 1'b1;
            memAddr_q  <= wordCnt_q[ADDR_W-1:0];
            memWdata_q <= '0;
            wordCnt_q  <= wordCnt_q + 16'd1;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_q[15:8] <= bus.in_data;
            xorAcc_q    <= xorAcc_q ^ bus.in_data;
            state_q     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_q    <= len_d;
            xorAcc_q <= xorAcc_q ^ bus.in_data;
            if ({1'b0, len_d} > RAM_SIZE_W) begin
              state_q <= ERROR;
            end else if (len_d == 16'd0) begin
              state_q <= CSUM;
            end else begin
              state_q <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            hiByte_q <= bus.in_data;
            xorAcc_q <= xorAcc_q ^ bus.in_data;
            state_q  <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (accept) begin
            memWe_q    <= 1'b1;
            memAddr_q  <= wordCnt_q[ADDR_W-1:0];
            memWdata_q <= {hiByte_q, bus.in_data};
            xorAcc_q   <= xorAcc_q ^ bus.in_data;
            wordCnt_q  <= wordCnt_q + 16'd1;
            if ((wordCnt_q + 16'd1) == len_q) begin
              state_q <= CSUM;
            end else begin
              state_q <= DATA_HI;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            if (bus.in_data == xorAcc_q) begin
              state_q <= DONE;
            end else begin
              state_q <= ERROR;
            end
          end
        end
        default: begin
          // DONE and ERROR hold until reset.
        end
      endcase
    end
  end

  // The CPU control outputs decode directly from the state register, so
  // load_done and load_err can never be high together.
  assign bus.in_ready  = inReady;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.cpu_reset = (state_q != DONE);
  assign bus.load_done = (state_q == DONE);
  assign bus.load_err  = (state_q == ERROR);

endmodule

// File: doc/mcpu_prog_loader.md
# mcpu_prog_loader

Boot-time program loader that sits directly upstream of the MCPU instruction/data RAM. After reset it zero-fills the RAM, then receives a length-prefixed, checksummed byte stream (e.g. from a UART receiver) and writes it as 16-bit instruction words from address 0. It holds the CPU in reset until the image is loaded and verified. It replaces hierarchical memory pokes with a synthesizable load path.

## Interface
- `RAM_SIZE`, default 256: number of 16-bit RAM words; must match the CPU RAM.
- `ADDR_W`, default 8: RAM address width; `2**ADDR_W >= RAM_SIZE`.
- `clk`, in, 1: sole clock, rising edge.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `in_data`, in, 8: stream byte.
- `in_valid`, in, 1: `in_data` valid.
- `in_ready`, out, 1: loader accepts a byte; transfer occurs when `in_valid && in_ready` at a rising edge.
- `mem_we`, out, 1: RAM write strobe, one word per cycle.
- `mem_addr`, out, ADDR_W: RAM write address.
- `mem_wdata`, out, 16: RAM write data, `{opcode, operands}` as the CPU decodes it.
- `cpu_reset`, out, 1: active-high reset to MCPU.
- `load_done`, out, 1: image loaded and checksum OK; sticky.
- `load_err`, out, 1: length or checksum error; sticky.

## Operation
- Stream format: `LEN_HI`, `LEN_LO` (N words, 16-bit), then N words as high byte then low byte, then one `CSUM` byte. `CSUM` is the XOR of every preceding byte, including the length bytes.
- States:
  - CLEAR: `mem_we=1`, `mem_wdata=0`, `mem_addr` steps 0..RAM_SIZE-1, one address per cycle; `in_ready=0`. Goes to LEN_HI after the last address.
  - LEN_HI / LEN_LO: accept the length bytes. After LEN_LO:
    - N > RAM_SIZE goes to ERROR.
    - N == 0 goes to CSUM.
    - Otherwise goes to DATA_HI.
  - DATA_HI: latch the high byte.
  - DATA_LO: on accept, issue the word write. Word k goes to address k. After word N-1 go to CSUM, else return to DATA_HI.
  - CSUM: compare the received byte with the running XOR. Match goes to DONE, mismatch goes to ERROR.
  - DONE: `in_ready=0`, `cpu_reset=0`, `load_done=1`. Terminal until reset.
  - ERROR: `in_ready=0`, `cpu_reset=1`, `load_err=1`. Terminal until reset.
- Running XOR and word counter clear on entry to LEN_HI.
- Arithmetic:
  - Word counter is 16 bits and is compared against the full 16-bit N, with no truncation.
  - `mem_addr` is the counter's low ADDR_W bits, always < RAM_SIZE.
- Bytes presented while `in_ready=0` are ignored and never consumed.
- `load_done` and `load_err` are never both 1.

## Timing
- Reset values: `in_ready=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `cpu_reset=1`, `load_done=0`, `load_err=0`. State is CLEAR.
- First CLEAR write (`mem_we=1`, addr 0) is in the first cycle after `reset_n` is sampled high. CLEAR lasts exactly RAM_SIZE cycles.
- `in_ready` rises in the cycle after the last CLEAR write. It is combinational from state: 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM.
- Word write is registered: `mem_we=1` with addr and data valid for exactly one cycle, in the cycle after the DATA_LO handshake. Back-to-back bytes sustain 1 word per 2 cycles.
- `load_done` and `cpu_reset=0` take effect in the cycle after the CSUM handshake. `load_err` asserts in the cycle after the offending handshake.
- Reset mid-operation (any state, including mid-CLEAR or mid-word): all outputs return to reset values on that edge. The partial image is discarded and CLEAR restarts from addr 0.
- `reset_n` low has priority over any simultaneous handshake.

## Structure
- Shared package `mcpu_pkg` holds:
  - state enum `loader_state_t` (CLEAR, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERROR);
  - `INSTR_W=16`;
  - CPU opcode constants used by benches to build images.
- Single module, with no sub-module: the byte-to-word assembly is one 8-bit register, so splitting it out adds nothing.
- Target size is roughly 150–200 lines of RTL.

## Test plan
- Reset, RAM_SIZE=256 -> `mem_we` high for exactly 256 consecutive cycles at addr 0..255 with data 0; `in_ready` rises the next cycle; `cpu_reset=1` throughout.
- Stream `00 02 80 08 81 01 0A` -> writes 0x8008@0 and 0x8101@1; `load_done=1` and `cpu_reset=0` one cycle after the `0A` handshake.
- Same stream with CSUM `0B` -> no `load_done`; `load_err=1`; `cpu_reset` stays 1; `in_ready=0` afterwards.
- Stream `01 01` (N=257 > 256) -> `load_err=1` the cycle after `LEN_LO`; no data writes.
- Stream `00 00 00` (N=0) -> no writes; `load_done=1`.
- Assert `reset_n=0` after the first data word of a 24-word image -> outputs return to reset values; CLEAR restarts from addr 0; the full reload then completes with `load_done=1`.
